// File: rtl/sdram_request_scheduler.sv
// Request FIFO, address decode and auto-refresh scheduling in front of the W9825G6KH SDRAM controller.
// Optional macro SDRAM_REFRESH_POSTPONE_EN lets refresh yield to queued traffic until it becomes urgent.
//
// state | meaning
// IDLE  | no command presented; choose refresh or next queued request
// REQ   | host read/write presented, waiting for cmd_ready
// REF   | auto-refresh presented, waiting for cmd_ready
module sdram_request_scheduler #(
    parameter int DEPTH            = 4,
    parameter int REFRESH_INTERVAL = 1250,
    parameter int REFRESH_URGENT   = 4,
    parameter int REFRESH_MAX      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ctrl_ready,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_op,
    output logic [1:0]  cmd_ba,
    output logic [12:0] cmd_row,
    output logic [8:0]  cmd_col,
    output logic [15:0] cmd_wdata,
    output logic        refresh_overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(REFRESH_INTERVAL);
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(REFRESH_INTERVAL - 1);
    localparam logic [3:0] PEND_MAX    = 4'(REFRESH_MAX);
    localparam logic [3:0] PEND_URGENT = 4'(REFRESH_URGENT);

    typedef enum logic [1:0] {IDLE, REQ, REF} state_t;

    // entry layout: [40] we, [39:16] word address, [15:0] write data
    logic [40:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [TW-1:0] timer;
    logic [3:0]    pending;
    state_t        state;

    logic        push, pop, ref_done, tick, fifo_empty, ref_cond;
    logic [40:0] head;

    assign req_ready  = (count != (AW+1)'(DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = req_valid && req_ready;
    assign pop        = (state == REQ) && cmd_ready;
    assign ref_done   = (state == REF) && cmd_ready;
    assign tick       = ctrl_ready && (timer == '0);
    assign head       = fifo_mem[rd_ptr];

`ifdef SDRAM_REFRESH_POSTPONE_EN
    assign ref_cond = (pending >= PEND_URGENT) || ((pending != '0) && fifo_empty);
`else
    // urgent is always at least one pending, so this reduces to "any refresh owed"
    assign ref_cond = (pending != '0) || (pending >= PEND_URGENT);
`endif

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {req_we, req_addr, req_wdata};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer           <= TIMER_RELOAD;
            pending         <= '0;
            refresh_overrun <= 1'b0;
        end else if (!ctrl_ready) begin
            timer   <= TIMER_RELOAD;
            pending <= '0;
        end else begin
            timer <= tick ? TIMER_RELOAD : timer - 1'b1;
            case ({tick, ref_done})
                2'b10: begin
                    if (pending == PEND_MAX) refresh_overrun <= 1'b1;
                    else                     pending <= pending + 1'b1;
                end
                2'b01:   if (pending != '0) pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_valid <= 1'b0;
            cmd_op    <= 2'b00;
            cmd_ba    <= '0;
            cmd_row   <= '0;
            cmd_col   <= '0;
            cmd_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl_ready && ref_cond) begin
                        state     <= REF;
                        cmd_valid <= 1'b1;
                        cmd_op    <= 2'b10;
                        cmd_ba    <= '0;
                        cmd_row   <= '0;
                        cmd_col   <= '0;
                        cmd_wdata <= '0;
                    end else if (ctrl_ready && !fifo_empty) begin
                        state     <= REQ;
                        cmd_valid <= 1'b1;
                        cmd_op    <= {1'b0, head[40]};
                        cmd_ba    <= head[39:38];
                        cmd_row   <= head[37:25];
                        cmd_col   <= head[24:16];
                        cmd_wdata <= head[15:0];
                    end
                end
                REQ, REF: begin
                    // losing ctrl_ready means the controller re-initialises; the
                    // request stays queued and is presented again afterwards
                    if (cmd_ready || !ctrl_ready) begin
                        state     <= IDLE;
                        cmd_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/sdram_request_scheduler.md
# sdram_request_scheduler

Front-end stage feeding the W9825G6KH-6 SDRAM controller. It accepts host read/write requests into a small FIFO, splits the flat word address into bank/row/column, and generates periodic auto-refresh requests that keep the 8192-refresh / 64 ms budget. It presents one command at a time to the controller over a valid/ready handshake and holds everything idle until the controller reports initialisation complete.

## Interface
Parameters:
- `DEPTH`, default 4: request FIFO entries (power of two, ≥2).
- `REFRESH_INTERVAL`, default 1250: clk cycles between refresh ticks (7.5 µs at 166 MHz).
- `REFRESH_URGENT`, default 4: pending-refresh count that forces refresh ahead of queued requests.
- `REFRESH_MAX`, default 8: saturation limit for pending refreshes.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: 166 MHz system clock, same clock as the controller.
- `rst_n` in 1: asynchronous active-low reset.
- `ctrl_ready` in 1: controller initialisation done.
- `req_valid` in 1: host request valid.
- `req_ready` out 1: FIFO can accept.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 24: word address; [23:22] bank, [21:9] row, [8:0] column.
- `req_wdata` in 16: write data, ignored for reads.
- `cmd_valid` out 1: command presented to the controller.
- `cmd_ready` in 1: controller accepts the command.
- `cmd_op` out 2: 00 read, 01 write, 10 auto-refresh, 11 never driven.
- `cmd_ba` out 2, `cmd_row` out 13, `cmd_col` out 9, `cmd_wdata` out 16: command payload.
- `refresh_overrun` out 1: sticky; set when a refresh tick arrives while pending = `REFRESH_MAX`.

## Operation
- FIFO: push on `req_valid && req_ready`. `req_ready = !full`, computed from the registered count. A pop in the same cycle does not free a slot for a push that cycle.
- Refresh timer: counts down from `REFRESH_INTERVAL-1` while `ctrl_ready` is high. On reaching 0 it ticks and reloads.
- `pending` is a 4-bit counter:
  - tick only: +1, saturating at `REFRESH_MAX`.
  - refresh handshake only: −1.
  - tick and refresh handshake in the same cycle: unchanged.
  - tick while saturated: sets `refresh_overrun`.
- While `ctrl_ready` is low:
  - timer held at reload value.
  - `pending` cleared.
  - `cmd_valid` held 0.
  - FIFO still accepts requests.
- FSM states: IDLE, REQ, REF.
  - IDLE → REF when the refresh condition holds (see Configuration).
  - IDLE → REQ when the FIFO is non-empty and the refresh condition is false. The head entry is copied into the output registers.
  - REQ/REF hold `cmd_valid=1` with a stable payload until `cmd_ready`. A presented command is never withdrawn or replaced.
  - On handshake: return to IDLE, and pop the FIFO (REQ) or decrement `pending` (REF).
- REF payload: `cmd_op=10`; ba/row/col/wdata driven 0.
- Decode is fixed: ba = addr[23:22], row = addr[21:9], col = addr[8:0].
- Reset (async assert):
  - FIFO emptied, `pending`=0, timer reloaded, state IDLE.
  - `cmd_valid`=0, `cmd_op`=00, all payload outputs 0, `refresh_overrun`=0.
  - `req_ready`=1, since the FIFO is empty.
  - Reset mid-handshake drops the command silently.

## Timing
- A request pushed at edge N (FIFO empty, no refresh due, `ctrl_ready` high) gives `cmd_valid`=1 after edge N+1.
- After a handshake at edge M, the next command is valid after edge M+1. This is one IDLE bubble: maximum one command per 2 cycles.
- A tick at edge T, with IDLE and the refresh condition met, gives REF `cmd_valid` after edge T+1.
- All outputs except `req_ready` are registered.
- `refresh_overrun` is cleared only by reset.

## Configuration
- `SDRAM_REFRESH_POSTPONE_EN` defined:
  - refresh condition = `pending ≥ REFRESH_URGENT` || (`pending ≥ 1` && FIFO empty).
  - Refresh yields to queued traffic until urgent.
- Undefined:
  - refresh condition = `pending ≥ 1`.
  - Refresh always wins over queued requests in IDLE.

## Test plan
- Reset release with `ctrl_ready`=0, 2000 cycles, with 3 pushed writes: `cmd_valid` stays 0, `pending`=0, `req_ready` goes 0 only after `DEPTH` pushes.
- `ctrl_ready`=1, push read addr 0xC0_3A5, `cmd_ready`=1: `cmd_valid` one cycle after the push with `cmd_op`=00, ba=3, row=0x0001, col=0x1A5.
- Write 0xBEEF with `cmd_ready` low for 5 cycles: payload stable throughout, single handshake, FIFO pops exactly once.
- Idle host, `cmd_ready`=1: REF commands issued every 1250 cycles ±1, `pending` never exceeds 1.
- POSTPONE_EN, continuous writes: first REF is issued when `pending` reaches 4. Without the macro, REF comes within 2 cycles of the first tick.
- `cmd_ready`=0 for 11 × 1250 cycles: `pending` saturates at 8, `refresh_overrun`=1 and stays 1 after traffic resumes, cleared by `rst_n` pulse.
